// File: rtl/snoopy_bus_requester_if.sv
// Bus, arbiter, responder and cache-fill signals of the snoopy bus requester.
// The requester owns the master modport; the environment uses slave.
interface snoopy_bus_requester_if #(
    parameter int OFFSET_WIDTH = 4,
    parameter int INDEX_WIDTH  = 4,
    parameter int TAG_WIDTH    = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int STATE_WIDTH  = 2
);
    localparam int AW = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

    logic                    missRequest;
    logic                    missExclusive;
    logic                    upgradeRequest;
    logic [AW-1:0]           requestAddress;
    logic [STATE_WIDTH-1:0]  newState;
    logic                    arbiterRequest;
    logic                    arbiterGrant;
    logic [1:0]              busCommand;
    logic [AW-1:0]           busAddress;
    logic                    readEnabled;
    logic                    functionComplete;
    logic [DATA_WIDTH-1:0]   busData;
    logic [INDEX_WIDTH-1:0]  cacheIndex;
    logic [OFFSET_WIDTH-1:0] cacheOffset;
    logic [TAG_WIDTH-1:0]    cacheTag;
    logic [DATA_WIDTH-1:0]   cacheDataOut;
    logic                    cacheWriteData;
    logic                    cacheWriteState;
    logic [STATE_WIDTH-1:0]  cacheStateOut;
    logic                    done;

    modport master (
        input  missRequest, missExclusive, upgradeRequest,
        input  requestAddress, newState,
        input  arbiterGrant, functionComplete, busData,
        output arbiterRequest, busCommand, busAddress, readEnabled,
        output cacheIndex, cacheOffset, cacheTag, cacheDataOut,
        output cacheWriteData, cacheWriteState, cacheStateOut, done
    );

    modport slave (
        output missRequest, missExclusive, upgradeRequest,
        output requestAddress, newState,
        output arbiterGrant, functionComplete, busData,
        input  arbiterRequest, busCommand, busAddress, readEnabled,
        input  cacheIndex, cacheOffset, cacheTag, cacheDataOut,
        input  cacheWriteData, cacheWriteState, cacheStateOut, done
    );
endinterface

// File: rtl/snoopy_bus_requester.sv
// Snoopy bus requester: block fills (BUS_READ / BUS_READ_EXCLUSIVE) and
// data-less BUS_INVALIDATE upgrades, then installs tag and coherence state.
module snoopy_bus_requester #(
    parameter int OFFSET_WIDTH = 4,
    parameter int INDEX_WIDTH  = 4,
    parameter int TAG_WIDTH    = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int STATE_WIDTH  = 2
) (
    input logic clock,
    input logic reset,
    snoopy_bus_requester_if.master bus
);
    localparam int AW = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_READ = 2'd1;
    localparam logic [1:0] CMD_RDX  = 2'd2;
    localparam logic [1:0] CMD_INV  = 2'd3;

    typedef enum logic [2:0] {
        IDLE, ARBITRATE, READ, ACK, INVALIDATE, DONE
    } state_t;

    state_t                  state, state_next;
    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  index;
    logic [STATE_WIDTH-1:0]  install;
    logic [1:0]              command;
    logic [OFFSET_WIDTH-1:0] word;
    logic                    inv_second;
    logic                    accept;
    logic                    active;
    logic                    unused_offset;

    // The block offset of the request address carries no meaning here.
    assign unused_offset = ^bus.requestAddress[OFFSET_WIDTH-1:0];

    assign accept = (state == IDLE) && (bus.missRequest || bus.upgradeRequest);
    assign active = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tag        <= '0;
            index      <= '0;
            install    <= '0;
            command    <= CMD_NONE;
            word       <= '0;
            inv_second <= 1'b0;
        end else begin
            state      <= state_next;
            inv_second <= (state == INVALIDATE) && !inv_second;
            if (accept) begin
                tag     <= bus.requestAddress[AW-1 -: TAG_WIDTH];
                index   <= bus.requestAddress[OFFSET_WIDTH +: INDEX_WIDTH];
                install <= bus.newState;
                if (bus.missRequest)
                    command <= bus.missExclusive ? CMD_RDX : CMD_READ;
                else
                    command <= CMD_INV;
            end
            if (state == ACK)
                word <= word + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:       if (accept) state_next = ARBITRATE;
            ARBITRATE:  if (bus.arbiterGrant)
                            state_next = (command == CMD_INV) ? INVALIDATE : READ;
            READ:       if (bus.functionComplete) state_next = ACK;
            ACK:        state_next = (word == '1) ? DONE : READ;
            INVALIDATE: if (inv_second) state_next = DONE;
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Everything below decodes state; only the READ write strobe sees the ack.
    assign bus.arbiterRequest  = active;
    assign bus.busCommand      = active ? command : CMD_NONE;
    assign bus.busAddress      = active ? {tag, index, word} : '0;
    assign bus.readEnabled     = (state == READ);
    assign bus.cacheIndex      = active ? index : '0;
    assign bus.cacheTag        = active ? tag : '0;
    assign bus.cacheOffset     = word;
    assign bus.cacheWriteData  = (state == READ) && bus.functionComplete;
    assign bus.cacheDataOut    = bus.cacheWriteData ? bus.busData : '0;
    assign bus.cacheWriteState = (state == DONE);
    assign bus.cacheStateOut   = (state == DONE) ? install : '0;
    assign bus.done            = (state == DONE);
endmodule

// File: tb/tb_snoopy_bus_requester.sv
// Scoreboard bench for snoopy_bus_requester: a memory model feeds the
// responder; expected cache writes and installs are queued at issue time.
module tb_snoopy_bus_requester;
    localparam int OW = 4, IW = 4, TW = 8, DW = 32, SW = 2;
    localparam int AW = TW + IW + OW;
    localparam int WORDS = 1 << OW;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    snoopy_bus_requester_if #(.OFFSET_WIDTH(OW), .INDEX_WIDTH(IW),
        .TAG_WIDTH(TW), .DATA_WIDTH(DW), .STATE_WIDTH(SW)) bus();

    snoopy_bus_requester #(.OFFSET_WIDTH(OW), .INDEX_WIDTH(IW),
        .TAG_WIDTH(TW), .DATA_WIDTH(DW), .STATE_WIDTH(SW)) dut (
        .clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic [IW-1:0] idx;
        logic [OW-1:0] off;
        logic [DW-1:0] data;
    } wr_t;
    typedef struct {
        logic [TW-1:0] tag;
        logic [IW-1:0] idx;
        logic [SW-1:0] st;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int tests = 0, fails = 0;
    logic [1:0] cur_cmd = 2'd0;
    int gdelay = 0, lat_min = 1, lat_max = 1;
    bit noise = 1'b0, gblock = 1'b0;

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return {a, ~a} ^ 32'h9E37_79B9;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arbiter: grants after gdelay request cycles unless blocked.
    initial begin
        int cnt;
        cnt = 0;
        bus.arbiterGrant = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (!bus.arbiterRequest) begin
                cnt = 0;
                bus.arbiterGrant = 1'b0;
            end else begin
                cnt++;
                bus.arbiterGrant = (cnt > gdelay) && !gblock;
            end
        end
    end

    // Responder: acks on the lat-th read cycle; optional stray acks otherwise.
    initial begin
        int rc, lat;
        rc = 0;
        lat = 1;
        bus.functionComplete = 1'b0;
        bus.busData = '0;
        forever begin
            @(posedge clock); #1;
            if (bus.readEnabled) begin
                if (rc == 0) lat = $urandom_range(lat_max, lat_min);
                rc++;
                bus.functionComplete = (rc >= lat);
                bus.busData = (rc >= lat) ? mem(bus.busAddress) : $urandom;
            end else begin
                rc = 0;
                bus.functionComplete = noise && ($urandom_range(1, 0) == 1);
                bus.busData = $urandom;
            end
        end
    end

    // Monitor
    initial begin
        wr_t w;
        dn_t d;
        forever begin
            @(negedge clock);
            if (reset) continue;
            if (dq.size() != 0) begin
                check("bus_cmd", {bus.arbiterRequest, bus.busCommand}, {1'b1, cur_cmd});
                if (cur_cmd == 2'd3) check("inv_no_read", bus.readEnabled, 0);
            end else begin
                check("idle_bus", {bus.arbiterRequest, bus.busCommand, bus.readEnabled}, 0);
            end
            check("done_eq_ws", bus.done, bus.cacheWriteState);
            if (bus.cacheWriteData) begin
                if (wq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: offset %0d with no write expected",
                             bus.cacheOffset);
                end else begin
                    w = wq.pop_front();
                    check("wr_offset", bus.cacheOffset, w.off);
                    check("wr_index", bus.cacheIndex, w.idx);
                    check("wr_data", bus.cacheDataOut, w.data);
                    check("wr_read_en", bus.readEnabled, 1);
                end
            end
            if (bus.cacheWriteState) begin
                check("words_left_at_done", wq.size(), 0);
                if (dq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: install with none expected");
                end else begin
                    d = dq.pop_front();
                    check("dn_tag", bus.cacheTag, d.tag);
                    check("dn_index", bus.cacheIndex, d.idx);
                    check("dn_state", bus.cacheStateOut, d.st);
                end
            end
        end
    end

    function automatic int exp_len(input bit miss, input int gd, input int l);
        return miss ? gd + 1 + WORDS * (l + 1) + 1 : gd + 1 + 2 + 1;
    endfunction

    // Caller is at posedge+1; the request is sampled at the next edge.
    task automatic start(input bit miss, input bit upg, input bit excl,
                         input logic [AW-1:0] addr, input logic [SW-1:0] st);
        wr_t w;
        dn_t d;
        logic [AW-1:0] a;
        bus.missRequest = miss;
        bus.upgradeRequest = upg;
        bus.missExclusive = excl;
        bus.requestAddress = addr;
        bus.newState = st;
        @(posedge clock); #1;
        bus.missRequest = 1'b0;
        bus.upgradeRequest = 1'b0;
        bus.missExclusive = $urandom_range(1, 0) == 1;
        bus.requestAddress = AW'($urandom);
        bus.newState = SW'($urandom);
        if (miss) begin
            cur_cmd = excl ? 2'd2 : 2'd1;
            for (int i = 0; i < WORDS; i++) begin
                a = {addr[AW-1:OW], OW'(i)};
                w.idx = addr[OW +: IW];
                w.off = OW'(i);
                w.data = mem(a);
                wq.push_back(w);
            end
        end else begin
            cur_cmd = 2'd3;
        end
        d.tag = addr[AW-1 -: TW];
        d.idx = addr[OW +: IW];
        d.st = st;
        dq.push_back(d);
    endtask

    task automatic finish(input int len, input bit upg_mid, input bit drop);
        int n, dn;
        bit seen, dropped;
        n = 0;
        dn = 0;
        seen = 1'b0;
        dropped = 1'b0;
        while (!seen && n < 2000) begin
            @(negedge clock);
            n++;
            seen = bus.done;
            if (upg_mid && n == 10) bus.upgradeRequest = 1'b1;
            if (upg_mid && n == 11) bus.upgradeRequest = 1'b0;
            if (drop && !dropped && bus.readEnabled && bus.cacheOffset == 3) begin
                gblock = 1'b1;
                dropped = 1'b1;
                dn = n;
            end
            if (gblock && n == dn + 5) gblock = 1'b0;
        end
        gblock = 1'b0;
        check("completed", seen, 1);
        if (seen && len >= 0) check("latency", n, len);
        repeat (3) @(negedge clock);
        check("idle_after", bus.arbiterRequest, 0);
        @(posedge clock); #1;
    endtask

    initial begin
        bit miss, upg, excl;
        int l;
        reset = 1'b1;
        bus.missRequest = 1'b0;
        bus.upgradeRequest = 1'b0;
        bus.missExclusive = 1'b0;
        bus.requestAddress = '0;
        bus.newState = '0;
        repeat (3) @(posedge clock); #1;
        check("reset_state", {bus.arbiterRequest, bus.busCommand, bus.readEnabled,
              bus.cacheWriteData, bus.cacheWriteState, bus.done, bus.busAddress,
              bus.cacheOffset, bus.cacheTag, bus.cacheIndex}, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Read fill, grant after 3 cycles, single-cycle acks
        gdelay = 3; lat_min = 1; lat_max = 1;
        start(1, 0, 0, 16'h5A37, 2'd2);
        finish(exp_len(1, 3, 1), 0, 0);

        // Exclusive fill, slow responder, stray acks outside READ
        gdelay = 1; lat_min = 4; lat_max = 4; noise = 1'b1;
        start(1, 0, 1, 16'hC31F, 2'd3);
        finish(exp_len(1, 1, 4), 0, 0);
        noise = 1'b0;

        // Upgrade with immediate grant
        gdelay = 0; lat_min = 1; lat_max = 1;
        start(0, 1, 0, 16'h7E40, 2'd1);
        finish(exp_len(0, 0, 1), 0, 0);

        // Miss beats upgrade; upgrade pulsed mid-fill is dropped
        gdelay = 2;
        start(1, 1, 0, 16'h1234, 2'd1);
        finish(exp_len(1, 2, 1), 1, 0);

        // Grant withdrawn for 5 cycles during word 3
        gdelay = 0; lat_min = 2; lat_max = 2;
        start(1, 0, 1, 16'hA5B0, 2'd2);
        finish(exp_len(1, 0, 2), 0, 1);

        // Asynchronous reset after word 7, then fill right after release
        lat_min = 1; lat_max = 1;
        start(1, 0, 0, 16'h6F00, 2'd3);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!(bus.cacheWriteData && bus.cacheOffset == 7) && n < 500);
            check("reached_word7", n < 500, 1);
        end
        #2 reset = 1'b1;
        wq.delete();
        dq.delete();
        #1;
        check("async_reset", {bus.arbiterRequest, bus.busCommand, bus.readEnabled,
              bus.cacheWriteData, bus.cacheWriteState, bus.done, bus.busAddress,
              bus.cacheOffset, bus.cacheTag, bus.cacheIndex}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        start(1, 0, 0, 16'h9C5A, 2'd1);
        finish(exp_len(1, 0, 1), 0, 0);

        // Randomized mix
        for (int t = 0; t < 20; t++) begin
            int k;
            k = $urandom_range(2, 0);
            miss = (k != 1);
            upg = (k != 0);
            excl = $urandom_range(1, 0) == 1;
            gdelay = $urandom_range(3, 0);
            noise = $urandom_range(1, 0) == 1;
            if ($urandom_range(1, 0) == 1) begin
                l = $urandom_range(3, 1);
                lat_min = l;
                lat_max = l;
            end else begin
                l = -1;
                lat_min = 1;
                lat_max = 3;
            end
            start(miss, upg, excl, AW'($urandom), SW'($urandom));
            finish((l < 0 && miss) ? -1 : exp_len(miss, gdelay, l), 0, 0);
        end
        noise = 1'b0;
        check("queues_drained", wq.size() + dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
